instruction_fetch: RTL and testbench

RV32I instruction fetch stage: the producer side of the IF/ID interface consumed by `instruction_decode`. It owns the program counter, issues in-order requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PCs in a small queue. It presents one instruction per enabled cycle on `o_if_inst`/`o_if_pc`. It handles pipeline stalls (`clk_en`) and control-flow redirects (`i_flush`), inserting NOPs (`addi x0,x0,0` = 32'h00000013) when no valid instruction is available.

---
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : RV32I fetch stage with credit-limited imem requests,
// response queue and an IF/ID output register.  Rev 1.0
// ============================================================================
module instruction_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_flush_target,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_if_inst,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  output logic                  o_if_valid
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_q, out_d, drop_q, drop_d, iq_cnt_q, iq_cnt_d;
  logic [AW-1:0]         pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
  logic [AW-1:0]         iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d, ifpc_q, ifpc_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] pcf_q     [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] iq_inst_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] iq_pc_q   [FIFO_DEPTH];

  logic [CW:0]           w_inflight;
  logic                  w_grant, w_drop, w_accept, w_pop, w_bypass, w_push;
  logic [DATA_WIDTH-1:0] w_rsp_pc;

  // Credit covers outstanding requests (including ones that will be dropped) plus queued words.
  assign w_inflight  = {1'b0, out_q} + {1'b0, iq_cnt_q};
  assign o_imem_req  = rst_n && !i_flush && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = pc_q;

  assign w_grant  = o_imem_req && i_imem_gnt;
  assign w_drop   = i_imem_rvalid && (drop_q != '0);
  assign w_accept = i_imem_rvalid && !w_drop && !i_flush;
  assign w_rsp_pc = pcf_q[pcf_rd_q];
  assign w_pop    = clk_en && !i_flush && (iq_cnt_q != '0);
  assign w_bypass = clk_en && (iq_cnt_q == '0) && w_accept;
  assign w_push   = w_accept && !w_bypass;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + CW'(w_grant) - CW'(i_imem_rvalid);
    drop_d   = drop_q;
    pcf_wr_d = pcf_wr_q;
    pcf_rd_d = pcf_rd_q;
    iq_wr_d  = iq_wr_q;
    iq_rd_d  = iq_rd_q;
    iq_cnt_d = iq_cnt_q;
    inst_d   = inst_q;
    ifpc_d   = ifpc_q;
    valid_d  = valid_q;
    if (i_flush) begin
      // No grant is possible while flushing, so out_d is exactly what is still in flight.
      pc_d     = i_flush_target & ~(DATA_WIDTH'(3));
      drop_d   = out_d;
      pcf_wr_d = '0;
      pcf_rd_d = '0;
      iq_wr_d  = '0;
      iq_rd_d  = '0;
      iq_cnt_d = '0;
      inst_d   = NOP;
      valid_d  = 1'b0;
    end else begin
      if (w_grant) begin
        pc_d     = pc_q + DATA_WIDTH'(4);
        pcf_wr_d = pcf_wr_q + 1'b1;
      end
      if (w_drop)   drop_d   = drop_q - 1'b1;
      if (w_accept) pcf_rd_d = pcf_rd_q + 1'b1;
      if (w_push)   iq_wr_d  = iq_wr_q + 1'b1;
      if (w_pop)    iq_rd_d  = iq_rd_q + 1'b1;
      iq_cnt_d = iq_cnt_q + CW'(w_push) - CW'(w_pop);
      if (clk_en) begin
        if (iq_cnt_q != '0) begin
          inst_d  = iq_inst_q[iq_rd_q];
          ifpc_d  = iq_pc_q[iq_rd_q];
          valid_d = 1'b1;
        end else if (w_accept) begin
          inst_d  = i_imem_rdata;
          ifpc_d  = w_rsp_pc;
          valid_d = 1'b1;
        end else begin
          inst_d  = NOP;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      pcf_wr_q <= '0;
      pcf_rd_q <= '0;
      iq_wr_q  <= '0;
      iq_rd_q  <= '0;
      iq_cnt_q <= '0;
      inst_q   <= NOP;
      ifpc_q   <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      pcf_wr_q <= pcf_wr_d;
      pcf_rd_q <= pcf_rd_d;
      iq_wr_q  <= iq_wr_d;
      iq_rd_q  <= iq_rd_d;
      iq_cnt_q <= iq_cnt_d;
      inst_q   <= inst_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) pcf_q[pcf_wr_q] <= pc_q;
    if (w_push) begin
      iq_inst_q[iq_wr_q] <= i_imem_rdata;
      iq_pc_q[iq_wr_q]   <= w_rsp_pc;
    end
  end

  assign o_if_inst  = inst_q;
  assign o_if_pc    = ifpc_q;
  assign o_if_valid = valid_q;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    i_imem_rvalid |-> (out_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : directed bench with a small in-order imem model.
// Rev 1.0
// ============================================================================
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic [31:0] flush_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  instruction_fetch #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .i_flush       (flush),
    .i_flush_target(flush_target),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_if_inst     (if_inst),
    .o_if_pc       (if_pc),
    .o_if_valid    (if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: record the handshake mid-cycle, then present the next response after the edge.
  task automatic step();
    @(negedge clk);
    if (rst_n && imem_req && gnt) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = mq_addr[0] | 32'hA000_0000;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    rvalid = 1'b0;
    rdata  = 32'h0;
    flush  = 1'b0;
    clk_en = 1'b1;
    lat    = 1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; flush_target = 32'h0;
    gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0; lat = 1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (if_inst !== 32'h13) begin errors++; $display("FAIL rst_inst got %h exp 00000013", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b exp 1", imem_req); end
  endtask

  task automatic test_stream();
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %b exp 0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, if_valid); end
      checks++; if (if_pc !== 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_pc, 32'(4*i)); end
      checks++; if (if_inst !== (32'(4*i) | 32'hA000_0000)) begin errors++; $display("FAIL stream_inst[%0d] got %h", i, if_inst); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    clk_en = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req0 got %b exp 1", imem_req); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (if_pc !== 32'h8 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got pc %h v %b exp 8 1", i, if_pc, if_valid); end
      if (i < 3) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_credit[%0d] got %b exp 0", i, imem_req); end
      end
    end
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 32'hC + 32'(4*i);
      checks++; if (if_pc !== exp_pc || if_valid !== 1'b1) begin errors++; $display("FAIL resume_pc[%0d] got %h v %b exp %h 1", i, if_pc, if_valid, exp_pc); end
      checks++; if (if_inst !== (exp_pc | 32'hA000_0000)) begin errors++; $display("FAIL resume_inst[%0d] got %h", i, if_inst); end
    end
  endtask

  task automatic test_flush_outstanding();
    int n;
    lat = 3;
    step();
    step();
    flush = 1'b1; flush_target = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_req got %b exp 0", imem_req); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", if_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_credit got %b exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL flush_target_req got %b %h exp 1 00000100", imem_req, imem_addr); end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL flush_timeout got %b exp 1", if_valid); end
    checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL flush_first_pc got %h exp 00000100", if_pc); end
    checks++; if (if_inst !== 32'hA000_0100) begin errors++; $display("FAIL flush_first_inst got %h exp a0000100", if_inst); end
  endtask

  task automatic test_no_grant();
    gnt = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL nognt_req[%0d] got %b %h exp 1 0", i, imem_req, imem_addr); end
      checks++; if (if_inst !== 32'h13 || if_valid !== 1'b0) begin errors++; $display("FAIL nognt_out[%0d] got %h %b exp 00000013 0", i, if_inst, if_valid); end
      step();
    end
    gnt = 1'b1;
  endtask

  task automatic test_flush_unaligned();
    apply_reset();
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL ua_setup_rvalid got %b exp 1", rvalid); end
    clk_en = 1'b0; flush = 1'b1; flush_target = 32'h103;
    step();
    flush = 1'b0; clk_en = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL ua_addr got %h %b exp 00000100 1", imem_addr, imem_req); end
    checks++; if (if_inst !== 32'h13 || if_valid !== 1'b0) begin errors++; $display("FAIL ua_nop got %h %b exp 00000013 0", if_inst, if_valid); end
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ua_gap got %b exp 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'hA000_0100) begin errors++; $display("FAIL ua_first got %b %h %h exp 1 00000100 a0000100", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_async_reset();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h13 || if_pc !== 32'h0) begin errors++; $display("FAIL arst_out got %b %h %h exp 0 00000013 0", if_valid, if_inst, if_pc); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_req got %b %h exp 0 0", imem_req, imem_addr); end
    mq_addr.delete();
    mq_due.delete();
    rvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart got %b %h exp 1 0", imem_req, imem_addr); end
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'hA000_0000) begin errors++; $display("FAIL arst_first got %b %h %h exp 1 0 a0000000", if_valid, if_pc, if_inst); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL arst_second got %b %h exp 1 4", if_valid, if_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_outstanding();
    test_no_grant();
    test_flush_unaligned();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
